shift_rows_stream: RTL and testbench
====================================

SHIFT_ROWS_STREAM -- requirements
Module: shift_rows_stream

Interface
REQ-001 Parameter NB, default 4: state columns (Rijndael Nb); legal 4, 6, 8; any other value SHALL cause an elaboration error.
REQ-002 Parameter CNT_W, default 16: width of the delivered-block counter.
REQ-003 Parameter DW, derived, fixed at 32*NB: data width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  input block valid.
REQ-007 in_ready  out  1  block can accept input; registered output.
REQ-008 in_data  in  DW  state, column-major; byte s(r,c) at bits [DW-1-8*(4c+r) -: 8].
REQ-009 in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows; sampled with in_data.
REQ-010 out_valid  out  1  output block valid.
REQ-011 out_ready  in  1  downstream accepts.
REQ-012 out_data  out  DW  shifted state, same byte layout.
REQ-013 blk_cnt  out  CNT_W  count of blocks delivered.

Function
REQ-014 Row offsets C1/C2/C3 SHALL be 1/2/3 for NB=4 and NB=6, and 1/3/4 for NB=8; row 0 is never shifted.
REQ-015 Forward mode: out s(r,c) = in s(r,(c+Cr) mod NB).
REQ-016 Inverse mode: out s(r,c) = in s(r,(c-Cr) mod NB).
REQ-017 Input handshake: transfer when in_valid && in_ready; output handshake: transfer when out_valid && out_ready.
REQ-018 The permutation SHALL be applied before registering; stored entries hold already-shifted data.
REQ-019 Storage: a 2-entry elastic buffer (main register driving out_data, plus a skid register); occupancy states EMPTY, ONE, TWO.
REQ-020 EMPTY: on input transfer -> load main, go to ONE.
REQ-021 ONE: input only -> load skid, go to TWO; output only -> EMPTY; both -> load main, stay ONE; neither -> hold.
REQ-022 TWO: output transfer -> main <= skid, go to ONE; no input is accepted.
REQ-023 in_ready SHALL be 1 exactly when state != TWO; it is registered and has no combinational path from out_ready.
REQ-024 out_valid SHALL be 1 exactly when state != EMPTY.
REQ-025 Latency: a block accepted at edge k SHALL be presented on out_data from edge k+1 when the buffer is empty beforehand.
REQ-026 Throughput: with out_ready held at 1, the block SHALL sustain one block per cycle.
REQ-027 Ordering: blocks SHALL leave in acceptance order; in_inv applies per block, and mixed modes are allowed back to back.
REQ-028 out_data and out_valid SHALL remain stable while out_valid && !out_ready.
REQ-029 blk_cnt SHALL increment by 1 on each output transfer and wrap from 2^CNT_W-1 to 0.
REQ-030 in_data is ignored when no input transfer occurs.

Reset
REQ-031 While rst=0 at a clk edge: state SHALL be EMPTY, in_ready 0, out_valid 0, out_data 0, blk_cnt 0, and the skid register 0.
REQ-032 in_ready SHALL rise on the first edge after rst returns to 1.
REQ-033 Reset mid-operation SHALL discard all buffered blocks with no output transfer; blk_cnt is not incremented.

Structure
REQ-034 A shared package (aes_pkg) SHALL hold: the NB legality check, the row-offset function (NB, row) -> offset, and the occupancy-state enum.
REQ-035 The permutation SHALL be a combinational sub-module, shift_rows_perm (parameter NB, inputs data and inv), instantiated once on the input path.

Verification
REQ-036 NB=4, forward, in_data=000102030405060708090a0b0c0d0e0f -> out_data=00050a0f04090e03080d02070c01060b one cycle later; blk_cnt=1 after handshake.
REQ-037 NB=4, inverse, same input -> out_data=000d0a0704010e0b0805020f0c090603.
REQ-038 Forward then inverse: feeding a random block through forward, then its output through inverse, SHALL return the original block; checked for NB=4, 6 and 8 over 1000 random blocks.
REQ-039 Backpressure: out_ready=0 while 3 blocks are offered -> 2 accepted, in_ready=0 after second, out_data stable; out_ready=1 -> blocks emerge in order and in_ready returns 1 one cycle after first drain.
REQ-040 Streaming: out_ready=1 with 8 back-to-back blocks of alternating mode -> 8 consecutive output cycles, correct per-block mode, blk_cnt=8.
REQ-041 Counter and reset: CNT_W=4, 17 blocks -> blk_cnt=1; rst=0 with 2 blocks buffered -> out_valid=0, blk_cnt=0 next edge, no output transfer.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the Rijndael ShiftRows blocks.
//   nb_legal   : 1 when NB (state columns) is a legal Rijndael block size
//   row_offset : row rotation amount Cr for a given NB and row
//   occ_e      : occupancy of the two-entry elastic buffer
package aes_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Row 0 never moves; the 256-bit block skips offset 2 in favour of 3/4.
  function automatic int row_offset(input int nb, input int row);
    if (row == 0) return 0;
    if ((nb == 8) && (row >= 2)) return row + 1;
    return row;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational (Inv)ShiftRows byte permutation.
//   data    : state, column-major, byte s(r,c) at [DW-1-8*(4c+r) -: 8]
//   inv     : 0 = rotate rows left (ShiftRows), 1 = rotate right (InvShiftRows)
//   shifted : permuted state, same byte layout
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter  int NB = 4,
  localparam int DW = 32 * NB
) (
  input  logic [DW-1:0] data,
  input  logic          inv,
  output logic [DW-1:0] shifted
);

  // Pure wiring: every source index is an elaboration-time constant.
  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int OFF = row_offset(NB, r);
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int SRC_FWD = (c + OFF) % NB;
      localparam int SRC_INV = (c - OFF + NB) % NB;
      assign shifted[DW-1-8*(4*c+r) -: 8] =
        inv ? data[DW-1-8*(4*SRC_INV+r) -: 8]
            : data[DW-1-8*(4*SRC_FWD+r) -: 8];
    end
  end

endmodule

// File: rtl/shift_rows_stream.sv
// Streaming (Inv)ShiftRows stage with a two-entry elastic buffer.
//   clk, rst            : rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake (in_ready is registered)
//   in_data, in_inv     : state block and per-block direction select
//   out_valid/out_ready : output handshake
//   out_data            : permuted state block
//   blk_cnt             : wrapping count of delivered blocks
module shift_rows_stream
  import aes_pkg::*;
#(
  parameter  int NB    = 4,
  parameter  int CNT_W = 16,
  localparam int DW    = 32 * NB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CNT_W-1:0] blk_cnt
);

  if (!nb_legal(NB)) begin : g_nb_illegal
    $error("shift_rows_stream: NB must be 4, 6 or 8");
  end

  occ_e             state_q, state_d;
  logic             in_ready_q;
  logic [DW-1:0]    main_q, skid_q, shifted;
  logic [CNT_W-1:0] blk_cnt_q;
  logic             in_xfer, out_xfer;
  logic             load_main, load_skid, main_from_skid;

  // Permute before storage so both buffer entries already hold output data.
  shift_rows_perm #(.NB(NB)) u_perm (
    .data    (in_data),
    .inv     (in_inv),
    .shifted (shifted)
  );

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid && out_ready;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      OCC_EMPTY: begin
        if (in_xfer) begin
          load_main = 1'b1;
          state_d   = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_d   = OCC_TWO;
        end else if (out_xfer) begin
          state_d   = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (out_xfer) begin
          main_from_skid = 1'b1;
          state_d        = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= OCC_EMPTY;
      in_ready_q <= 1'b0;
      // NOTE: the data registers are reset too, so a flushed buffer presents
      // all-zero data rather than a stale block.
      main_q     <= '0;
      skid_q     <= '0;
      blk_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      // Registered copy of "not full" for the state being entered.
      in_ready_q <= (state_d != OCC_TWO);
      if (load_main)           main_q <= shifted;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= shifted;
      if (out_xfer)            blk_cnt_q <= blk_cnt_q + CNT_W'(1);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != OCC_EMPTY);
  assign out_data  = main_q;
  assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_shift_rows_stream.sv
// Self-checking bench: DUT 0 is NB=4/CNT_W=4, DUTs 1 and 2 are NB=6 and NB=8.
module tb_shift_rows_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   in_valid, in_inv, out_ready;
  logic [255:0] in_data [3];
  wire  [2:0]   in_ready, out_valid;
  wire  [127:0] od0;
  wire  [191:0] od1;
  wire  [255:0] od2;
  wire  [3:0]   cnt0;
  wire  [15:0]  cnt1, cnt2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_rows_stream #(.NB(4), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][127:0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(od0), .blk_cnt(cnt0));

  shift_rows_stream #(.NB(6), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1][191:0]), .in_inv(in_inv[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(od1), .blk_cnt(cnt1));

  shift_rows_stream #(.NB(8), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(od2), .blk_cnt(cnt2));

  typedef struct {
    logic [127:0] data;
    bit           inv;
    logic [127:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] out_d(input int d);
    case (d)
      0:       return {128'b0, od0};
      1:       return {64'b0, od1};
      default: return od2;
    endcase
  endfunction

  // Reference: view the block as a 4 x nb byte matrix and rotate each row.
  function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input bit inv);
    logic [7:0]   m [4][8];
    logic [255:0] res = '0;
    int           top = 32 * nb - 1;
    int           rot [4];
    if (nb == 8) rot = '{0, 1, 3, 4};
    else         rot = '{0, 1, 2, 3};
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = d[top - 8*(4*c + r) -: 8];
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        int src = inv ? (c + nb - rot[r]) % nb : (c + rot[r]) % nb;
        res[top - 8*(4*c + r) -: 8] = m[r][src];
      end
    return res;
  endfunction

  function automatic logic [255:0] rand_blk(input int nb);
    logic [255:0] v;
    logic [255:0] mask;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    mask = (256'd1 << (32 * nb)) - 256'd1;
    return v & mask;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Send one block with out_ready high; return the block seen one cycle later.
  task automatic send_one(input int d, input logic [255:0] data, input bit inv,
                          output logic [255:0] got);
    int t = 0;
    while (!in_ready[d] && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t == 20) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at 0 on dut %0d", d);
    end
    in_data[d]  = data;
    in_inv[d]   = inv;
    in_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    check("latency_valid", 256'(out_valid[d]), 256'd1);
    got = out_d(d);
    @(posedge clk);
    #1;
  endtask

  // Back-to-back blocks of alternating mode with out_ready held high.
  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      logic [255:0] b = rand_blk(4);
      in_data[0]  = b;
      in_inv[0]   = i[0];
      in_valid[0] = 1'b1;
      check("stream_in_ready", 256'(in_ready[0]), 256'd1);
      @(posedge clk);
      #1;
      check("stream_out_valid", 256'(out_valid[0]), 256'd1);
      check("stream_data", out_d(0), ref_shift(b, 4, i[0]));
    end
    in_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    check("stream_drained", 256'(out_valid[0]), 256'd0);
  endtask

  initial begin
    vec_t         vecs [4];
    logic [255:0] got, got2, x;
    logic [255:0] bp [3];
    logic [127:0] q [$];
    int           nbs [3];
    int           acc;
    int           exp_cnt;

    nbs = '{4, 6, 8};
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h00050a0f04090e03080d02070c01060b};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1, 128'h000d0a0704010e0b0805020f0c090603};
    vecs[2] = '{128'h00050a0f04090e03080d02070c01060b, 1'b1, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[3] = '{128'h000d0a0704010e0b0805020f0c090603, 1'b0, 128'h000102030405060708090a0b0c0d0e0f};

    in_valid  = '0;
    in_inv    = '0;
    out_ready = 3'b111;
    for (int d = 0; d < 3; d++) in_data[d] = '0;

    // Reset state while rst is held low, then in_ready on the first edge after.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 256'(in_ready[0]), 256'd0);
    check("rst_out_valid", 256'(out_valid[0]), 256'd0);
    check("rst_out_data", out_d(0), 256'd0);
    check("rst_blk_cnt", 256'(cnt0), 256'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_ready", 256'(in_ready), 256'd7);

    // Directed known-answer vectors.
    for (int i = 0; i < 4; i++) begin
      send_one(0, {128'b0, vecs[i].data}, vecs[i].inv, got);
      check("vector_data", got, {128'b0, vecs[i].exp});
      check("vector_blk_cnt", 256'(cnt0), 256'(i + 1));
    end

    // Random forward-then-inverse round trips on every block size.
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 1000; k++) begin
        x = rand_blk(nbs[d]);
        send_one(d, x, 1'b0, got);
        check("roundtrip_fwd", got, ref_shift(x, nbs[d], 1'b0));
        send_one(d, got, 1'b1, got2);
        check("roundtrip_back", got2, x);
      end

    // Backpressure: three offers with out_ready low, only two fit.
    do_reset();
    out_ready[0] = 1'b0;
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      bp[k]       = rand_blk(4);
      in_data[0]  = bp[k];
      in_inv[0]   = k[0];
      in_valid[0] = 1'b1;
      if (in_ready[0]) acc++;
      @(posedge clk);
      #1;
      if (k == 1) check("bp_full_ready", 256'(in_ready[0]), 256'd0);
    end
    in_valid[0] = 1'b0;
    check("bp_accepted", 256'(acc), 256'd2);
    for (int k = 0; k < 3; k++) begin
      check("bp_stable_valid", 256'(out_valid[0]), 256'd1);
      check("bp_stable_data", out_d(0), ref_shift(bp[0], 4, 1'b0));
      check("bp_stall_ready", 256'(in_ready[0]), 256'd0);
      @(posedge clk);
      #1;
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_second_data", out_d(0), ref_shift(bp[1], 4, 1'b1));
    check("bp_ready_back", 256'(in_ready[0]), 256'd1);
    @(posedge clk);
    #1;
    check("bp_empty", 256'(out_valid[0]), 256'd0);
    check("bp_blk_cnt", 256'(cnt0), 256'd2);

    // Streaming at full rate.
    do_reset();
    stream(8);
    check("stream8_blk_cnt", 256'(cnt0), 256'd8);

    // Counter wrap with a 4-bit counter.
    do_reset();
    stream(17);
    check("wrap_blk_cnt", 256'(cnt0), 256'd1);

    // Reset while two blocks are buffered.
    out_ready[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_data[0]  = rand_blk(4);
      in_valid[0] = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    check("midrst_full", 256'(in_ready[0]), 256'd0);
    rst          = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 256'(out_valid[0]), 256'd0);
    check("midrst_blk_cnt", 256'(cnt0), 256'd0);
    check("midrst_out_data", out_d(0), 256'd0);
    check("midrst_in_ready", 256'(in_ready[0]), 256'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_release_ready", 256'(in_ready[0]), 256'd1);
    check("midrst_still_empty", 256'(out_valid[0]), 256'd0);

    // Random valid/ready traffic against a FIFO-of-two model.
    exp_cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit ix, ox;
      bit inv_r;
      @(negedge clk);
      inv_r        = 1'($urandom);
      in_valid[0]  = 1'($urandom);
      out_ready[0] = ($urandom_range(0, 3) != 0);
      in_inv[0]    = inv_r;
      in_data[0]   = rand_blk(4);
      check("rand_in_ready", 256'(in_ready[0]), 256'(q.size() < 2));
      check("rand_out_valid", 256'(out_valid[0]), 256'(q.size() > 0));
      check("rand_blk_cnt", 256'(cnt0), 256'(exp_cnt % 16));
      ix = in_valid[0] && in_ready[0];
      ox = out_valid[0] && out_ready[0];
      if (ox && q.size() > 0) begin
        check("rand_data", out_d(0), {128'b0, q.pop_front()});
        exp_cnt++;
      end
      if (ix) q.push_back(ref_shift(in_data[0], 4, inv_r) >> 0);
    end
    in_valid[0] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
